// File: rtl/ct_hpcp_cntx_ctrl.sv
// Control and accumulation for one programmable HPM counter: WARL event select,
// a two-stage increment path, sticky overflow, freeze-on-overflow and overflow interrupt.
module ct_hpcp_cntx_ctrl #(
  parameter int CNT_WIDTH = 64,
  parameter int EVT_NUM   = 52
) (
  input  logic                 hpcp_clk,
  input  logic                 hpcp_rst,
  input  logic                 evt_wen,
  input  logic [63:0]          evt_wdata,
  input  logic                 cnt_wen,
  input  logic [CNT_WIDTH-1:0] cnt_wdata,
  input  logic                 cnt_inhibit,
  input  logic                 hpcp_cnt_en,
  input  logic                 ovf_freeze_en,
  input  logic                 int_en,
  input  logic                 ovf_clr,
  input  logic [3:0]           mhpmcntx_adder,
  output logic [63:0]          mhpmevtx_value,
  output logic [CNT_WIDTH-1:0] mhpmcntx_value,
  output logic                 cntx_ovf,
  output logic                 cntx_int_vld
);

  typedef enum logic [1:0] {IDLE, COUNT, FROZEN} state_t;

  state_t               r_state;
  logic [63:0]          r_evt;
  logic [3:0]           r_adder_p1;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic                 r_int;

  logic [63:0]          w_evt_next;
  logic                 w_evt_nz;
  logic [CNT_WIDTH:0]   w_sum;
  logic                 w_add_en;
  logic                 w_ovf_set;
  logic                 w_ovf_next;
  logic                 w_run;

  // Illegal event codes read back as 0 (no event); legal codes fit in the low 6 bits.
  function automatic logic [63:0] evt_legalize(input logic [63:0] d);
    return (d < 64'(EVT_NUM)) ? {58'd0, d[5:0]} : 64'd0;
  endfunction

  function automatic logic [CNT_WIDTH:0] cnt_add(input logic [CNT_WIDTH-1:0] c,
                                                 input logic [3:0]           a);
    return {1'b0, c} + {{(CNT_WIDTH-3){1'b0}}, a};
  endfunction

  assign w_evt_next = evt_wen ? evt_legalize(evt_wdata) : r_evt;
  assign w_evt_nz   = |w_evt_next;
  assign w_sum      = cnt_add(r_cnt, r_adder_p1);
  assign w_add_en   = !cnt_wen && (r_state != FROZEN);
  assign w_ovf_set  = w_add_en && w_sum[CNT_WIDTH];
  // A new overflow beats a simultaneous clear.
  assign w_ovf_next = w_ovf_set || (r_ovf && !ovf_clr);
  assign w_run      = !cnt_inhibit && hpcp_cnt_en;

  always_ff @(posedge hpcp_clk or posedge hpcp_rst) begin
    if (hpcp_rst) begin
      r_state    <= IDLE;
      r_evt      <= 64'd0;
      r_adder_p1 <= 4'd0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_evt <= w_evt_next;
      // Stage 1: sample the increment; any CSR write flushes it so nothing stale lands.
      r_adder_p1 <= (!evt_wen && !cnt_wen && (r_state == COUNT) && w_run) ? mhpmcntx_adder : 4'd0;
      // Stage 2: accumulate, with software writes taking priority over the add.
      if (cnt_wen)
        r_cnt <= cnt_wdata;
      else if (r_state != FROZEN)
        r_cnt <= w_sum[CNT_WIDTH-1:0];
      r_ovf <= w_ovf_next;
      r_int <= w_ovf_next && int_en;
      if (w_run) begin
        case (r_state)
          IDLE:    if (w_evt_nz) r_state <= COUNT;
          COUNT: begin
            if (!w_evt_nz)                        r_state <= IDLE;
            else if (w_ovf_set && ovf_freeze_en)  r_state <= FROZEN;
          end
          FROZEN:  if (ovf_clr || cnt_wen) r_state <= w_evt_nz ? COUNT : IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign mhpmevtx_value = r_evt;
  assign mhpmcntx_value = r_cnt;
  assign cntx_ovf       = r_ovf;
  assign cntx_int_vld   = r_int;

endmodule

// File: doc/ct_hpcp_cntx_ctrl.md
Name: ct_hpcp_cntx_ctrl

Overview:
Per-counter control and accumulation block for one programmable hardware performance counter (mhpmcounterX/mhpmeventX pair).
- Holds the event-select register and drives it to the event adder-select mux.
- Registers the returned 4-bit increment and accumulates it into the counter.
- Handles CSR writes, inhibit/enable gating, overflow flagging, freeze-on-overflow and the overflow interrupt.
- One instance per programmable counter inside the HPCP top.

Parameters:
CNT_WIDTH, 64, counter width in bits.
EVT_NUM, 52, number of legal event codes (0..EVT_NUM-1); code 0 means no event.

Ports:
hpcp_clk  input  1  block clock
hpcp_rst  input  1  reset, asynchronous, active-high
evt_wen  input  1  CSR write strobe for mhpmeventX
evt_wdata  input  64  CSR write data for mhpmeventX
cnt_wen  input  1  CSR write strobe for mhpmcounterX
cnt_wdata  input  CNT_WIDTH  CSR write data for mhpmcounterX
cnt_inhibit  input  1  mcountinhibit bit for this counter
hpcp_cnt_en  input  1  global count enable (privilege/mode filter already applied)
ovf_freeze_en  input  1  stop counting after overflow
int_en  input  1  overflow interrupt enable
ovf_clr  input  1  clear sticky overflow flag
mhpmcntx_adder  input  4  increment selected by the adder-select mux for the current event
mhpmevtx_value  output  64  event-select register, drives the adder-select mux
mhpmcntx_value  output  CNT_WIDTH  counter value
cntx_ovf  output  1  sticky overflow flag
cntx_int_vld  output  1  registered overflow interrupt request

Behaviour:
Reset (asynchronous, hpcp_rst=1)
- mhpmevtx_value=0, mhpmcntx_value=0, adder_ff=0, cntx_ovf=0, cntx_int_vld=0, FSM=IDLE.
- Assertion mid-operation discards any in-flight increment.

Event register (WARL)
- evt_wen: if evt_wdata < EVT_NUM, store evt_wdata; otherwise store 0.
- Bits [63:6] are always stored 0.

Increment pipeline
- Stage 1 (adder_ff): captures mhpmcntx_adder when FSM=COUNT, cnt_inhibit=0 and hpcp_cnt_en=1; captures 0 otherwise.
- adder_ff is also forced to 0 in any cycle with evt_wen or cnt_wen, so no stale increment is applied.
- Stage 2: counter += adder_ff.
- Latency: an event sampled at edge N is visible in mhpmcntx_value after edge N+1 (2-edge pipeline).

Counter update priority (highest first)
- cnt_wen: counter=cnt_wdata, and adder_ff is discarded.
- FSM=FROZEN: hold.
- Otherwise: counter = counter + adder_ff, modulo 2^CNT_WIDTH.

Overflow
- Carry-out of the add sets cntx_ovf; the counter wraps to the low bits (e.g. all-ones + 3 gives 2).
- ovf_clr clears cntx_ovf. If set and clear occur in the same cycle, set wins.
- cnt_wen does not clear cntx_ovf.
- cntx_int_vld is registered: next value = cntx_ovf_next & int_en.

FSM
- IDLE: entered when mhpmevtx_value==0. Goes to COUNT when the event register becomes non-zero.
- COUNT:
  - Goes to IDLE on event 0.
  - Goes to FROZEN on overflow when ovf_freeze_en=1.
- FROZEN: counting stops.
  - Exit to COUNT on ovf_clr or cnt_wen (to IDLE if the event is 0).
  - An event write to a non-zero code stays FROZEN.
- While inhibit=1 or hpcp_cnt_en=0, the FSM state is held; only increments are gated.

Test Plan:
1. Reset, write event 5, drive adder=3 for 4 cycles -> counter reaches 12, with the first increment visible 2 edges after the adder is sampled.
2. Write event 60 -> mhpmevtx_value=0, FSM=IDLE, and the counter holds even with adder=7.
3. Counter preload 0xFFFF_FFFF_FFFF_FFFE, adder=3, ovf_freeze_en=0, int_en=1 -> counter=1, cntx_ovf=1, cntx_int_vld=1 the following cycle.
4. Same preload with ovf_freeze_en=1 -> counter=1 then holds despite adder=2; ovf_clr -> counting resumes; simultaneous new overflow plus ovf_clr keeps cntx_ovf=1.
5. Counting with adder=4 and cnt_wen=1 with cnt_wdata=100 in the same cycle -> counter=100 next cycle with no lost or extra increment from the flushed stage. cnt_inhibit=1 -> counter frozen at its current value.
6. Assert hpcp_rst mid-count -> all outputs return to 0 immediately (asynchronously); after deassert the counter stays 0 until a new event write.
